// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers beside the EX-stage ALU.
// Latency XLEN+1 cycles from start to done_o; dependent HI/LO accesses stall while busy.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    input  logic            rd_hilo_i,
    input  logic            wr_hi_i,
    input  logic            wr_lo_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            stall_o
);
    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, ADJ} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [2*XLEN-1:0]   work;
    logic [XLEN-1:0]     opnd;
    logic [XLEN-1:0]     a_orig;
    logic [1:0]          op_q;
    logic                neg_res;
    logic                neg_rem;

    logic                accept;
    logic                is_signed;
    logic [XLEN-1:0]     a_mag;
    logic [XLEN-1:0]     b_mag;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_nxt;
    logic [XLEN:0]       div_shift;
    logic [XLEN:0]       div_diff;
    logic [2*XLEN-1:0]   div_nxt;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix;
    logic [XLEN-1:0]     rem_fix;

    assign accept    = start_i & ~flush_i;
    assign is_signed = ~op_i[0];
    assign a_mag     = (is_signed & a_i[XLEN-1]) ? -a_i : a_i;
    assign b_mag     = (is_signed & b_i[XLEN-1]) ? -b_i : b_i;

    // Multiply: work = {accumulator, remaining multiplier bits}, shifted right each step.
    assign mul_sum = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, opnd} : '0);
    assign mul_nxt = {mul_sum, work[XLEN-1:1]};

    // Divide: work = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    assign div_shift = work[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_nxt   = div_diff[XLEN] ? {div_shift[XLEN-1:0], work[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0],  work[XLEN-2:0], 1'b1};

    assign prod_fix = neg_res ? -work : work;
    assign quo_fix  = neg_res ? -work[XLEN-1:0] : work[XLEN-1:0];
    assign rem_fix  = neg_rem ? -work[2*XLEN-1:XLEN] : work[2*XLEN-1:XLEN];

    assign busy_o  = (state != IDLE);
    assign stall_o = busy_o & ~flush_i & (start_i | rd_hilo_i | wr_hi_i | wr_lo_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = CALC;
            end
            CALC: begin
                if (flush_i)                          state_nxt = IDLE;
                else if (cnt == CNT_W'(XLEN - 1))     state_nxt = ADJ;
            end
            ADJ: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt     <= '0;
            work    <= '0;
            opnd    <= '0;
            a_orig  <= '0;
            op_q    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
            done_o  <= 1'b0;
        end else begin
            done_o <= (state == ADJ) & ~flush_i;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= op_i;
                        opnd    <= op_i[1] ? b_mag : a_mag;
                        work    <= {{XLEN{1'b0}}, (op_i[1] ? a_mag : b_mag)};
                        a_orig  <= a_i;
                        neg_res <= is_signed & (a_i[XLEN-1] ^ b_i[XLEN-1]);
                        neg_rem <= is_signed & a_i[XLEN-1];
                        cnt     <= '0;
                    end else if (!flush_i) begin
                        if (wr_hi_i) hi_o <= wdata_i;
                        if (wr_lo_i) lo_o <= wdata_i;
                    end
                end
                CALC: begin
                    if (!flush_i) begin
                        work <= op_q[1] ? div_nxt : mul_nxt;
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                ADJ: begin
                    if (!flush_i) begin
                        if (!op_q[1]) begin
                            hi_o <= prod_fix[2*XLEN-1:XLEN];
                            lo_o <= prod_fix[XLEN-1:0];
                        end else if (opnd == '0) begin
                            // Divide by zero: all-ones quotient, dividend passed through.
                            hi_o <= a_orig;
                            lo_o <= '1;
                        end else begin
                            hi_o <= rem_fix;
                            lo_o <= quo_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit attached beside the execute-stage ALU. It gives the core MULT/MULTU/DIV/DIVU with HI/LO result registers and MTHI/MTLO writes. While an operation is in flight it raises a stall request toward the ID/EX pipeline register when a dependent HI/LO access arrives. A branch-taken flush from MEM aborts the operation in flight.

Parameters:
XLEN, 32, operand/result width; even, >= 4
CNT_W, $clog2(XLEN+1), iteration counter width (derived, not overridden)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
start_i  in  1  issue operation in op_i on a_i/b_i
op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a_i  in  XLEN  rs operand (multiplicand / dividend), already forwarded
b_i  in  XLEN  rt operand (multiplier / divisor), already forwarded
flush_i  in  1  abort: the instruction in flight is squashed
rd_hilo_i  in  1  MFHI/MFLO in EX this cycle
wr_hi_i  in  1  MTHI: write wdata_i to HI
wr_lo_i  in  1  MTLO: write wdata_i to LO
wdata_i  in  XLEN  MTHI/MTLO data
hi_o  out  XLEN  HI register
lo_o  out  XLEN  LO register
busy_o  out  1  operation in flight (state CALC or ADJ)
done_o  out  1  one-cycle pulse when HI/LO take a new result
stall_o  out  1  combinational stall request to ID/EX

Behaviour:
- Reset (async, rst_i=1): state IDLE; hi_o=0, lo_o=0, busy_o=0, done_o=0; counter and working registers are cleared. Reset mid-operation discards the operation.
- States:
  - IDLE: if start_i & ~flush_i at an edge, latch |a|, |b| (magnitudes for signed ops, raw for unsigned), the sign-fix flags, op and the original a_i. Clear the counter. Go to CALC.
  - CALC: one iteration per edge, XLEN iterations. At the edge where counter reaches XLEN, go to ADJ.
  - ADJ: apply sign fix-up, write HI/LO, set done_o for the following cycle, go to IDLE.
- Latency: start sampled at edge E. HI/LO update and done_o rises at edge E+XLEN+1. A new start is accepted in the done_o cycle.
- Multiply: shift-add on magnitudes into a 2*XLEN product. For MULT, negate the product when the operand signs differ. HI=product[2X-1:X], LO=product[X-1:0].
- Divide: restoring algorithm on magnitudes. For DIV, negate the quotient when the signs differ; the remainder takes the dividend's sign. LO=quotient, HI=remainder.
  - Divide by zero: LO=all ones, HI=original a_i, regardless of signedness. Latency is unchanged.
  - DIV of most-negative by -1: LO=most-negative, HI=0.
- MTHI/MTLO: applied at the edge only when state is IDLE and no start is accepted at that edge. When busy they are blocked via stall_o.
- stall_o = busy_o & (start_i | rd_hilo_i | wr_hi_i | wr_lo_i), unless flush_i=1, in which case stall_o=0.
- A start_i while busy is ignored; the requester is held by stall_o.
- flush_i in CALC or ADJ: at the next edge go to IDLE. HI/LO are unchanged and no done_o pulse is produced.
- flush_i in IDLE together with start_i: the start is dropped. Flush has priority over every other input.
- busy_o and done_o are registered outputs; done_o is never high when busy_o is high.

Test Plan:
- XLEN=32, MULT a=0xFFFFFFFD (-3), b=7 -> done_o exactly 33 cycles after the start edge, HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIVU 100/7 -> LO=14, HI=2. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV a=5, b=0 -> LO=0xFFFFFFFF, HI=5, same 33-cycle latency. DIVU a=0xFFFFFFF0, b=0 -> HI=0xFFFFFFF0.
- Preload HI=0x11, LO=0x22 via MTHI/MTLO, start MULT, assert flush_i at cycle 10 -> busy_o=0 next cycle, no done_o, HI/LO stay 0x11/0x22. In a separate run, start_i+flush_i in the same cycle -> stays IDLE.
- rd_hilo_i, wr_lo_i and a second start_i while busy -> stall_o=1 every such cycle, and LO is not written before done_o. The same requests in the done_o cycle -> stall_o=0, and MTLO after done_o overwrites LO.
- Assert rst_i at cycle 5 of a DIV -> hi_o/lo_o/busy_o/done_o go to 0 immediately (asynchronously). After release, a fresh MULTU 3*5 -> LO=15, HI=0. Repeat the arithmetic checks at XLEN=8 (MULT 0x80*0x80 -> HI=0x40, LO=0x00).
